// File: rtl/phy_rx_serial_paral.sv
// rtl/phy_rx_serial_paral.sv - serial-to-parallel PHY receiver with COM-symbol byte alignment (optional PHY_RX_LOS_EN loss-of-sync monitor)
module phy_rx_serial_paral #(
    parameter logic [7:0]  COM_BYTE    = 8'hBC,
    parameter int unsigned ALIGN_COUNT = 4
`ifdef PHY_RX_LOS_EN
    ,
    parameter int unsigned LOS_COUNT   = 4
`endif
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        ALIGNING = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    // com_cnt counts aligned COMs; the last needed one is reached when com_cnt+1 == ALIGN_COUNT
    localparam logic [3:0] ALIGN_LAST = 4'(ALIGN_COUNT - 1);
`ifdef PHY_RX_LOS_EN
    localparam logic [3:0] LOS_LAST   = 4'(LOS_COUNT - 1);
`endif

    state_t     state;
    // Only the seven most recent bits are kept: the eighth bit of the match
    // window is always the bit being sampled at the current edge.
    logic [6:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] com_cnt;
`ifdef PHY_RX_LOS_EN
    logic [3:0] los_cnt;
`endif

    logic [7:0] w;
    logic       boundary;
    logic       com_hit;

    assign w        = {sr, serial_in};
    assign boundary = (bit_cnt == 3'd7);
    assign com_hit  = (w == COM_BYTE);

    // Serial history: shift in one bit per clk_8f edge, MSB first
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr <= w[6:0];
        end
    end

    // Alignment FSM with registered data/valid/strobe/active outputs
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state       <= SEARCH;
            bit_cnt     <= '0;
            com_cnt     <= '0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
`ifdef PHY_RX_LOS_EN
            los_cnt     <= '0;
`endif
        end else begin
            case (state)
                SEARCH: begin
                    // Hunt for COM at any phase; a hit defines slot phase
                    byte_strobe <= 1'b0;
                    bit_cnt     <= '0;
                    if (com_hit) begin
                        com_cnt <= 4'd1;
                        state   <= ALIGNING;
                    end
                end

                ALIGNING: begin
                    byte_strobe <= 1'b0;
                    bit_cnt     <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (com_hit) begin
                            com_cnt <= com_cnt + 4'd1;
                            if (com_cnt == ALIGN_LAST) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            // Chain broken: any non-COM slot restarts the hunt
                            state   <= SEARCH;
                            com_cnt <= '0;
                        end
                    end
                end

                ACTIVE: begin
                    bit_cnt     <= bit_cnt + 3'd1;
                    byte_strobe <= boundary;
                    if (boundary) begin
                        if (!com_hit) begin
                            data_out  <= w;
                            valid_out <= 1'b1;
                        end else begin
                            // Idle slot: strobe still fires, data_out keeps last byte
                            valid_out <= 1'b0;
                        end
                    end
`ifdef PHY_RX_LOS_EN
                    if (boundary) begin
                        if (com_hit) begin
                            los_cnt <= '0;
                        end
                    end else if (com_hit) begin
                        // COM seen off the slot grid: the lane has slipped
                        if (los_cnt == LOS_LAST) begin
                            state       <= SEARCH;
                            active      <= 1'b0;
                            valid_out   <= 1'b0;
                            byte_strobe <= 1'b0;
                            los_cnt     <= '0;
                            com_cnt     <= '0;
                            bit_cnt     <= '0;
                        end else begin
                            los_cnt <= los_cnt + 4'd1;
                        end
                    end
`endif
                end

                default: begin
                    state  <= SEARCH;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
